sprite_dma_ctrl: RTL
====================

SPRITE_DMA_CTRL -- requirements
Module: sprite_dma_ctrl

Interface
REQ-001 The block SHALL have the parameter ADDR_WIDTH, default 8: the transfer length is 2^ADDR_WIDTH words.
REQ-002 The block SHALL have the parameter DATA_WIDTH, default 8: the word width.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have the port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have the port vblank, input, 1 bit: the vertical blank level; its rising edge is the transfer trigger.
REQ-006 The block SHALL have the port enable, input, 1 bit: trigger qualifier, sampled on the edge-detect cycle.
REQ-007 The block SHALL have the port src_addr, output, ADDR_WIDTH bits: read/write address to the source RAM.
REQ-008 The block SHALL have the port src_q, input, DATA_WIDTH bits: source RAM read data, valid one clock after src_addr is registered.
REQ-009 The block SHALL have the port src_we, output, 1 bit: source RAM write strobe, used only by the clear phase.
REQ-010 The block SHALL have the port src_din, output, DATA_WIDTH bits: source RAM write data.
REQ-011 The block SHALL have the port dst_addr, output, ADDR_WIDTH bits: destination buffer write address.
REQ-012 The block SHALL have the port dst_din, output, DATA_WIDTH bits: destination buffer write data.
REQ-013 The block SHALL have the port dst_we, output, 1 bit: destination write strobe.
REQ-014 The block SHALL have the port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-015 The block SHALL have the port done, output, 1 bit: one-cycle pulse at the end of a transfer.

Function
REQ-016 The FSM states SHALL be IDLE, PRIME, COPY, CLEAR (macro-only) and DONE.
REQ-017 Edge detect: vblank SHALL be registered, and a trigger SHALL occur on the clock edge where vblank=1 and the registered vblank=0.
REQ-018 IDLE -> PRIME SHALL occur on a trigger with enable=1; a trigger with enable=0 SHALL be ignored.
REQ-019 PRIME SHALL present src_addr=0 for one cycle and then go to COPY.
REQ-020 COPY SHALL increment src_addr every cycle, with the read counter saturating after 2^ADDR_WIDTH-1.
REQ-021 COPY SHALL assert dst_we with dst_addr=k and dst_din=src_q for k = 0..2^ADDR_WIDTH-1, in order, with no gaps.
REQ-022 The first dst_we SHALL occur 2 cycles after the trigger edge; dst_we SHALL be high for exactly 2^ADDR_WIDTH consecutive cycles.
REQ-023 After the last write, the FSM SHALL go to CLEAR if the macro is defined, and to DONE otherwise.
REQ-024 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-025 Triggers arriving while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-026 vblank falling mid-transfer SHALL NOT abort the transfer.
REQ-027 Address counters SHALL be ADDR_WIDTH bits wide; a separate terminal-count flag SHALL end each phase, and wrap to 0 SHALL NOT retrigger writes.
REQ-028 src_we and dst_we SHALL NOT both be high in the same cycle.
REQ-029 Outside COPY, dst_we SHALL be 0; outside CLEAR, src_we SHALL be 0.

Reset
REQ-030 Assertion of reset_n=0 SHALL immediately force IDLE and drive busy=0, done=0, dst_we=0, src_we=0, src_addr=0, dst_addr=0, dst_din=0, src_din=0, and the registered vblank=0.
REQ-031 Reset mid-transfer SHALL abandon the transfer with no further writes; a partial destination is acceptable.
REQ-032 After deassertion, a vblank already high SHALL NOT trigger until it falls and rises again.

Configuration
REQ-033 With SPRITE_DMA_CLEAR_EN defined, CLEAR SHALL drive src_we=1, src_din=0 and src_addr=k for k = 0..2^ADDR_WIDTH-1, one per cycle, beginning the cycle after the last dst_we; done SHALL pulse the cycle after the final clear write.
REQ-034 Without SPRITE_DMA_CLEAR_EN, the CLEAR state and its logic SHALL be absent, src_we SHALL be tied 0, src_din SHALL be tied 0, and done SHALL pulse the cycle after the final dst_we.

Verification
REQ-035 Basic copy (ADDR_WIDTH=4, source word k = 8'hA0+k, vblank 0->1, enable=1): 16 dst writes with dst_addr 0..15 and dst_din A0..AF; first write at trigger+2; one done pulse.
REQ-036 Disabled trigger (enable=0 at the vblank edge): dst_we, busy and done stay 0.
REQ-037 Retrigger while busy (second vblank rising edge at write 5): exactly 16 writes and a single done.
REQ-038 Reset mid-copy (reset_n=0 after write 7): dst_we=0 asynchronously, busy=0, no writes after reset; vblank held high through reset produces no transfer.
REQ-039 Clear with SPRITE_DMA_CLEAR_EN: after 16 copy writes, 16 src_we cycles at addresses 0..15 with data 0; the source reads back all zero; done at the end.
REQ-040 Back-to-back frames: two vblank pulses 40 cycles apart each produce a full, correct 16-word copy.

Source files
------------

// File: rtl/sprite_dma_ctrl.sv
// ---------------------------------------------------------------------------
// sprite_dma_ctrl
//
// Copies a 2^ADDR_WIDTH-word sprite table from a synchronous-read source RAM
// into a destination buffer once per vertical blank.
//
// A rising edge on vblank, qualified by enable, starts a transfer:
//   PRIME : src_addr = 0 is presented so the first read word arrives
//           one clock later.
//   COPY  : src_addr advances every cycle, saturating at the last word.
//           Each returned word is registered onto dst_addr/dst_din with
//           dst_we high. The destination writes are a contiguous burst of
//           2^ADDR_WIDTH cycles, the first one two clocks after the
//           trigger edge.
//   CLEAR : (only when SPRITE_DMA_CLEAR_EN is defined) writes zero to every
//           source word, one per cycle, in address order.
//   DONE  : one-cycle done pulse, then back to IDLE.
// Triggers seen while busy are dropped, not queued. vblank falling during a
// transfer has no effect.
//
// Build option:
//   SPRITE_DMA_CLEAR_EN - include the CLEAR phase. When undefined the phase
//                         does not exist and src_we/src_din are tied to 0.
//
// Ports:
//   clk       in   single clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   vblank    in   vertical blank level; its rising edge is the trigger
//   enable    in   trigger qualifier, sampled on the edge-detect cycle
//   src_addr  out  source RAM address (read in COPY, write in CLEAR)
//   src_q     in   source RAM read data, one clock after src_addr
//   src_we    out  source RAM write strobe (CLEAR only)
//   src_din   out  source RAM write data (always zero)
//   dst_addr  out  destination write address
//   dst_din   out  destination write data
//   dst_we    out  destination write strobe
//   busy      out  high whenever the FSM is not IDLE
//   done      out  one-cycle pulse at the end of a transfer
// ---------------------------------------------------------------------------
module sprite_dma_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  vblank,
   input  logic                  enable,
   output logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [DATA_WIDTH-1:0] src_q,
   output logic                  src_we,
   output logic [DATA_WIDTH-1:0] src_din,
   output logic [ADDR_WIDTH-1:0] dst_addr,
   output logic [DATA_WIDTH-1:0] dst_din,
   output logic                  dst_we,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

`ifdef SPRITE_DMA_CLEAR_EN
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRIME = 3'd1,
      S_COPY  = 3'd2,
      S_CLEAR = 3'd3,
      S_DONE  = 3'd4
   } state_e;
`else
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRIME = 3'd1,
      S_COPY  = 3'd2,
      S_DONE  = 3'd4
   } state_e;
`endif

   state_e                  state_q,    state_d;
   logic                    vblank_q,   vblank_d;
   logic                    armed_q,    armed_d;
   logic [ADDR_WIDTH-1:0]   rd_addr_q,  rd_addr_d;
   logic                    rd_tc_q,    rd_tc_d;
   logic [ADDR_WIDTH-1:0]   wr_idx_q,   wr_idx_d;
   logic                    wr_tc_q,    wr_tc_d;
   logic                    dst_we_q,   dst_we_d;
   logic [ADDR_WIDTH-1:0]   dst_addr_q, dst_addr_d;
   logic [DATA_WIDTH-1:0]   dst_din_q,  dst_din_d;

   logic                    trigger;
   logic [ADDR_WIDTH-1:0]   rd_addr_inc;

   // armed_q stays low after reset until vblank has been seen low, so a
   // vblank that is already high when reset is released cannot look like a
   // fresh rising edge.
   assign trigger     = vblank & ~vblank_q & armed_q;
   assign rd_addr_inc = rd_addr_q + ADDR_ONE;

   // -------------------------------------------------------------------------
   // Next-state and datapath logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so that no path
      // leaves one unassigned; otherwise synthesis infers a latch.
      state_d    = state_q;
      vblank_d   = vblank;
      armed_d    = armed_q | ~vblank;
      rd_addr_d  = rd_addr_q;
      rd_tc_d    = rd_tc_q;
      wr_idx_d   = wr_idx_q;
      wr_tc_d    = wr_tc_q;
      dst_we_d   = 1'b0;
      dst_addr_d = dst_addr_q;
      dst_din_d  = dst_din_q;

      unique case (state_q)
         S_IDLE: begin
            if (trigger && enable) begin
               state_d   = S_PRIME;
               rd_addr_d = '0;
               rd_tc_d   = 1'b0;
               wr_idx_d  = '0;
               wr_tc_d   = 1'b0;
            end
         end

         S_PRIME: begin
            // Address 0 is on the bus this cycle; move on to address 1.
            state_d   = S_COPY;
            rd_addr_d = rd_addr_inc;
            rd_tc_d   = (rd_addr_inc == LAST_ADDR);
         end

         S_COPY: begin
            // Read side runs one word ahead of the write side and parks on
            // the last address once it gets there.
            if (!rd_tc_q) begin
               rd_addr_d = rd_addr_inc;
               rd_tc_d   = (rd_addr_inc == LAST_ADDR);
            end

            // Write side: wr_tc_q, not the wrapped index, decides when the
            // burst is over, so wrapping back to 0 never restarts it.
            if (!wr_tc_q) begin
               dst_we_d   = 1'b1;
               dst_addr_d = wr_idx_q;
               dst_din_d  = src_q;
               if (wr_idx_q == LAST_ADDR) begin
                  wr_tc_d = 1'b1;
               end else begin
                  wr_idx_d = wr_idx_q + ADDR_ONE;
               end
            end else begin
               // This cycle carries the final registered write.
`ifdef SPRITE_DMA_CLEAR_EN
               state_d   = S_CLEAR;
               rd_addr_d = '0;
               rd_tc_d   = 1'b0;
`else
               state_d   = S_DONE;
`endif
            end
         end

`ifdef SPRITE_DMA_CLEAR_EN
         S_CLEAR: begin
            if (rd_tc_q) begin
               state_d = S_DONE;
            end else begin
               rd_addr_d = rd_addr_inc;
               rd_tc_d   = (rd_addr_inc == LAST_ADDR);
            end
         end
`endif

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         vblank_q   <= 1'b0;
         armed_q    <= 1'b0;
         rd_addr_q  <= '0;
         rd_tc_q    <= 1'b0;
         wr_idx_q   <= '0;
         wr_tc_q    <= 1'b0;
         dst_we_q   <= 1'b0;
         dst_addr_q <= '0;
         dst_din_q  <= '0;
      end else begin
         state_q    <= state_d;
         vblank_q   <= vblank_d;
         armed_q    <= armed_d;
         rd_addr_q  <= rd_addr_d;
         rd_tc_q    <= rd_tc_d;
         wr_idx_q   <= wr_idx_d;
         wr_tc_q    <= wr_tc_d;
         dst_we_q   <= dst_we_d;
         dst_addr_q <= dst_addr_d;
         dst_din_q  <= dst_din_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign src_addr = rd_addr_q;
   assign dst_we   = dst_we_q;
   assign dst_addr = dst_addr_q;
   assign dst_din  = dst_din_q;
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign src_din  = '0;

`ifdef SPRITE_DMA_CLEAR_EN
   assign src_we   = (state_q == S_CLEAR);
`else
   assign src_we   = 1'b0;
`endif

endmodule
